// File: rtl/fifo_demux_reader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_demux_reader_if: source-FIFO read port and destination bus       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface fifo_demux_reader_if #(
  parameter int DATA_SIZE = 12
);
  logic                 enable;
  logic                 fifo_empty;
  logic [DATA_SIZE-1:0] fifo_data_out;
  logic                 fifo_error;
  logic [3:0]           dest_pause;
  logic                 read;
  logic [3:0]           push;
  logic [DATA_SIZE-1:0] data_out;
  logic [7:0]           drained_count;
  logic                 error;

  modport master (
    output enable, fifo_empty, fifo_data_out, fifo_error, dest_pause,
    input  read, push, data_out, drained_count, error
  );

  modport slave (
    input  enable, fifo_empty, fifo_data_out, fifo_error, dest_pause,
    output read, push, data_out, drained_count, error
  );
endinterface
`default_nettype wire

// File: rtl/fifo_demux_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_demux_reader: pops the main FIFO and routes each word to one of  |
// | four destinations by its two MSBs. Rev 1.0                            |
// +----------------------------------------------------------------------+
module fifo_demux_reader #(
  parameter int DATA_SIZE   = 12,
  parameter int STALL_LIMIT = 15
) (
  input  wire logic          clk,
  input  wire logic          reset,
  fifo_demux_reader_if.slave bus
);

  localparam int c_stall_w = $clog2(STALL_LIMIT + 1);
  localparam logic [c_stall_w-1:0] c_stall_max  = c_stall_w'(STALL_LIMIT);
  localparam logic [c_stall_w-1:0] c_stall_last = c_stall_w'(STALL_LIMIT - 1);
  localparam logic [c_stall_w-1:0] c_stall_one  = c_stall_w'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POP  = 2'd1,
    S_WAIT = 2'd2,
    S_SEND = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 read_q, read_d;
  logic [DATA_SIZE-1:0] hold_q, hold_d;
  logic [c_stall_w-1:0] stall_cnt_q, stall_cnt_d;
  logic [7:0]           drained_q, drained_d;
  logic                 error_q, error_d;
  logic [3:0]           w_push;
  logic [1:0]           w_sel;
  logic                 w_can_pop;

  assign w_sel     = hold_q[DATA_SIZE-1:DATA_SIZE-2];
  assign w_can_pop = bus.enable && !bus.fifo_empty;

  always_comb begin
    state_d     = state_q;
    read_d      = 1'b0;
    hold_d      = hold_q;
    stall_cnt_d = stall_cnt_q;
    drained_d   = drained_q;
    error_d     = error_q | bus.fifo_error;
    w_push      = 4'b0000;
    case (state_q)
      S_IDLE: begin
        if (w_can_pop) begin
          state_d = S_POP;
          read_d  = 1'b1;
        end
      end
      S_POP: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        hold_d      = bus.fifo_data_out;
        stall_cnt_d = '0;
        state_d     = S_SEND;
      end
      S_SEND: begin
        if (!bus.dest_pause[w_sel]) begin
          w_push[w_sel] = 1'b1;
          drained_d     = drained_q + 8'd1;
          if (w_can_pop) begin
            state_d = S_POP;
            read_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          // Word is never dropped on a stall; only the error flag escalates.
          if (stall_cnt_q != c_stall_max) begin
            stall_cnt_d = stall_cnt_q + c_stall_one;
          end
          if (stall_cnt_q == c_stall_last) begin
            error_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      read_q      <= 1'b0;
      hold_q      <= '0;
      stall_cnt_q <= '0;
      drained_q   <= 8'd0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      read_q      <= read_d;
      hold_q      <= hold_d;
      stall_cnt_q <= stall_cnt_d;
      drained_q   <= drained_d;
      error_q     <= error_d;
    end
  end

  assign bus.read          = read_q;
  assign bus.push          = w_push;
  assign bus.data_out      = hold_q;
  assign bus.drained_count = drained_q;
  assign bus.error         = error_q;

endmodule
`default_nettype wire
